branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Sits between fetch/decode and EX, directly upstream of the two-level branch predictor's update interface.
- Records every fetched instruction's prediction (pc, predicted direction, predicted target) in an in-order FIFO.
- When EX resolves the oldest instruction, compares the stored prediction against the actual outcome. It then drives the predictor update port and raises a registered mispredict/redirect that flushes all wrong-path entries.

Parameters:
- DEPTH, 8, number of in-flight prediction entries (power of two, >=2).
- PTR_BITS, 3, log2(DEPTH).
- XLEN, 32, PC/target width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; queue and outputs clear when reset==0 at posedge.
- enq_valid  in  1  IF offers a prediction record.
- enq_ready  out  1  queue can accept: !full.
- enq_pc  in  XLEN  fetched PC.
- enq_pred_taken  in  1  predictor direction.
- enq_pred_target  in  XLEN  predicted target (meaningful only if enq_pred_taken).
- res_valid  in  1  EX resolves the oldest entry this cycle.
- res_is_branch  in  1  resolved instruction is a branch/jump.
- res_taken  in  1  actual direction (ignored if !res_is_branch).
- res_target  in  XLEN  actual taken target.
- upd_enable  out  1  registered update strobe to predictor.
- upd_pc  out  XLEN  to predictor ex_pc.
- upd_target  out  XLEN  to predictor ex_target.
- upd_is_branch  out  1  to predictor ex_is_branch.
- upd_taken  out  1  to predictor ex_branch_taken.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  correct next PC, valid with mispredict.
- empty  out  1  no entries.
- res_err  out  1  sticky: res_valid seen while empty.

Behaviour:
- Storage: circular buffer, head/tail pointers PTR_BITS wide plus count (0..DEPTH); pointers wrap DEPTH-1 -> 0.
- Enqueue fires on enq_valid && enq_ready; entry written at tail, tail+1.
- Dequeue fires on res_valid && !empty; head entry compared, head+1. Enqueue and dequeue in the same non-flush cycle leave the count unchanged.
- enq_ready = (count != DEPTH). There is no bypass when full, even if a dequeue occurs the same cycle.
- Mispredict condition, evaluated on a dequeue with pc4 = head.pc + 4 (mod 2^XLEN):
  - res_is_branch && (pred_taken != res_taken): mispredict.
  - res_is_branch && res_taken && pred_taken && pred_target != res_target: mispredict.
  - !res_is_branch && pred_taken: mispredict.
- redirect_pc = (res_is_branch && res_taken) ? res_target : pc4.
- Flush: on a mispredicting dequeue, the next state is count=0 and head=tail=0. Any same-cycle enqueue is discarded (wrong path).
- Outputs are registered, 1-cycle latency after the dequeue edge:
  - upd_enable=1 for every dequeue (branch or not).
  - upd_* carry head.pc, res_target, res_is_branch, res_taken.
  - mispredict pulses 1 cycle.
  - With no dequeue, upd_enable=0 and mispredict=0; data outputs hold their last values.
- res_valid while empty: ignored (no pointer change, no update), and res_err is set until reset.
- Reset (reset==0 at posedge), including mid-operation: count=0, head=tail=0, and all outputs 0 (upd_*, redirect_pc, mispredict, res_err, empty=1 combinational from count, enq_ready=1).
- Reset overrides simultaneous enq/res.

Optional Feature:
- Macro BRQ_STATS_EN.
- Defined: adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on each dequeue with res_is_branch.
  - stat_mispredicts increments on each mispredict-generating dequeue.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package brq_pkg holds:
  - constants DEPTH, PTR_BITS, XLEN;
  - the entry record typedef {pc, pred_taken, pred_target};
  - the function computing the mispredict condition, reused by the bench scoreboard.
- One natural sub-module: brq_fifo (storage, pointers, count, flush). Compare/update/redirect logic stays in the top.

Test Plan:
- Enqueue pc=0x100 pred_taken=0; resolve branch not-taken -> next cycle upd_enable=1, upd_pc=0x100, upd_taken=0, mispredict=0, empty=1.
- Enqueue pc=0x200 pred_taken=1 target=0x300; resolve taken target=0x340 -> mispredict=1, redirect_pc=0x340, queue flushed.
- Enqueue 3 entries (0x10,0x14,0x18), first predicted not-taken but resolves taken to 0x80; enqueue 0x1C same cycle -> mispredict, redirect_pc=0x80, count=0, 0x1C discarded.
- Fill 8 entries -> enq_ready=0; 9th enq_valid ignored; enq+res same cycle while full -> enqueue refused, count=7; wrap head/tail across 7->0 for 20 entries with correct FIFO order.
- Non-branch pc=0xFFFFFFFC predicted taken -> mispredict, redirect_pc=0x00000000 (wrap); res_valid on empty queue -> res_err=1, no upd_enable.
- Assert reset=0 with 4 entries queued and res_valid=1 -> all outputs 0, empty=1, res_err=0; with BRQ_STATS_EN, counters read 0 after reset and count 2 branches/1 mispredict after scenarios 1-2.

Source files
------------

// File: rtl/brq_pkg.sv
// ============================================================================
// brq_pkg : shared constants, entry record and mispredict rule for the
//           branch resolve queue.                             Rev 1.0
// ============================================================================
`default_nettype none

package brq_pkg;

  localparam int DEPTH    = 8;
  localparam int PTR_BITS = 3;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } brq_entry_t;

  localparam int ENTRY_W = $bits(brq_entry_t);

  // A non-branch that was predicted taken sent fetch down a bogus path.
  function automatic logic brq_mispredict(
    input brq_entry_t      e,
    input logic            is_branch,
    input logic            taken,
    input logic [XLEN-1:0] target
  );
    logic m;
    if (is_branch) begin
      m = (e.pred_taken != taken) ||
          (taken && e.pred_taken && (e.pred_target != target));
    end else begin
      m = e.pred_taken;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/brq_fifo.sv
// ============================================================================
// brq_fifo : circular prediction-record buffer with head/tail/count and a
//            single-cycle flush back to the empty state.          Rev 1.0
// ============================================================================
`default_nettype none

module brq_fifo
  import brq_pkg::*;
#(
  parameter int DEPTH    = brq_pkg::DEPTH,
  parameter int PTR_BITS = brq_pkg::PTR_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam logic [PTR_BITS:0] C_FULL = (PTR_BITS+1)'(DEPTH);

  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [PTR_BITS:0]   count_q, count_d;

  // Pointers are exactly PTR_BITS wide, so DEPTH-1 -> 0 wraps naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PTR_BITS'(1);
      if (pop_i)  head_d = head_q + PTR_BITS'(1);
      if (push_i && !pop_i)      count_d = count_q + (PTR_BITS+1)'(1);
      else if (!push_i && pop_i) count_d = count_q - (PTR_BITS+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[tail_q] <= wdata_i;
  end

  assign head_o  = mem_q[head_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_FULL);

endmodule

`default_nettype wire

// File: rtl/branch_resolve_queue.sv
// ============================================================================
// branch_resolve_queue : records predictions in order, checks them against EX
// resolution, drives predictor update and mispredict redirect.
// Optional macro BRQ_STATS_EN adds stat_branches / stat_mispredicts.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH    = brq_pkg::DEPTH,
  parameter int PTR_BITS = brq_pkg::PTR_BITS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [XLEN-1:0] enq_pc,
  input  logic            enq_pred_taken,
  input  logic [XLEN-1:0] enq_pred_target,
  input  logic            res_valid,
  input  logic            res_is_branch,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            upd_enable,
  output logic [XLEN-1:0] upd_pc,
  output logic [XLEN-1:0] upd_target,
  output logic            upd_is_branch,
  output logic            upd_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            empty,
  output logic            res_err
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  brq_entry_t         enq_e;
  brq_entry_t         head_e;
  logic [ENTRY_W-1:0] head_raw;
  logic               fifo_empty;
  logic               fifo_full;
  logic               enq_fire;
  logic               deq;
  logic               misp;
  logic [XLEN-1:0]    pc4;
  logic [XLEN-1:0]    redirect;

  logic            upd_enable_q,    upd_enable_d;
  logic [XLEN-1:0] upd_pc_q,        upd_pc_d;
  logic [XLEN-1:0] upd_target_q,    upd_target_d;
  logic            upd_is_branch_q, upd_is_branch_d;
  logic            upd_taken_q,     upd_taken_d;
  logic            mispredict_q,    mispredict_d;
  logic [XLEN-1:0] redirect_pc_q,   redirect_pc_d;
  logic            res_err_q,       res_err_d;

  assign enq_e    = '{pc: enq_pc, pred_taken: enq_pred_taken, pred_target: enq_pred_target};
  assign head_e   = brq_entry_t'(head_raw);
  assign enq_fire = enq_valid && !fifo_full;
  assign deq      = res_valid && !fifo_empty;
  assign misp     = deq && brq_mispredict(head_e, res_is_branch, res_taken, res_target);
  assign pc4      = head_e.pc + XLEN'(4);
  assign redirect = (res_is_branch && res_taken) ? res_target : pc4;

  // A mispredicting dequeue flushes; any same-cycle enqueue is wrong-path.
  brq_fifo #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (enq_fire),
    .wdata_i (enq_e),
    .pop_i   (deq),
    .flush_i (misp),
    .head_o  (head_raw),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    upd_enable_d    = deq;
    mispredict_d    = misp;
    upd_pc_d        = upd_pc_q;
    upd_target_d    = upd_target_q;
    upd_is_branch_d = upd_is_branch_q;
    upd_taken_d     = upd_taken_q;
    redirect_pc_d   = redirect_pc_q;
    res_err_d       = res_err_q | (res_valid && fifo_empty);
    if (deq) begin
      upd_pc_d        = head_e.pc;
      upd_target_d    = res_target;
      upd_is_branch_d = res_is_branch;
      upd_taken_d     = res_taken;
      redirect_pc_d   = redirect;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      upd_enable_q    <= 1'b0;
      upd_pc_q        <= '0;
      upd_target_q    <= '0;
      upd_is_branch_q <= 1'b0;
      upd_taken_q     <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      res_err_q       <= 1'b0;
    end else begin
      upd_enable_q    <= upd_enable_d;
      upd_pc_q        <= upd_pc_d;
      upd_target_q    <= upd_target_d;
      upd_is_branch_q <= upd_is_branch_d;
      upd_taken_q     <= upd_taken_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      res_err_q       <= res_err_d;
    end
  end

  assign upd_enable    = upd_enable_q;
  assign upd_pc        = upd_pc_q;
  assign upd_target    = upd_target_q;
  assign upd_is_branch = upd_is_branch_q;
  assign upd_taken     = upd_taken_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_pc_q;
  assign res_err       = res_err_q;
  assign empty         = fifo_empty;
  assign enq_ready     = !fifo_full;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (deq && res_is_branch && (stat_br_q != 32'hFFFF_FFFF)) stat_br_d = stat_br_q + 32'd1;
    if (misp && (stat_mp_q != 32'hFFFF_FFFF))                 stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
// ============================================================================
// tb_branch_resolve_queue : directed scenarios plus randomized traffic checked
// against a queue-based reference model.                         Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_queue;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic        enq_pred_taken;
  logic [31:0] enq_pred_target;
  logic        res_valid;
  logic        res_is_branch;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_enable;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_is_branch;
  logic        upd_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        empty;
  logic        res_err;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_queue dut (
    .clock           (clock),
    .reset           (reset),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_pc          (enq_pc),
    .enq_pred_taken  (enq_pred_taken),
    .enq_pred_target (enq_pred_target),
    .res_valid       (res_valid),
    .res_is_branch   (res_is_branch),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .upd_enable      (upd_enable),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_is_branch   (upd_is_branch),
    .upd_taken       (upd_taken),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .empty           (empty),
    .res_err         (res_err)
`ifdef BRQ_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ment_t;

  ment_t       mq[$];
  int          n_cmp;
  int          n_fail;
  logic        exp_upd_en;
  logic [31:0] exp_upd_pc;
  logic [31:0] exp_upd_tgt;
  logic        exp_upd_br;
  logic        exp_upd_tk;
  logic        exp_misp;
  logic [31:0] exp_redir;
  logic        exp_err;
  logic [31:0] exp_stat_br;
  logic [31:0] exp_stat_mp;

  // Reference: one clock of queue behaviour, computed from the resolve rules.
  task automatic step(input logic ev, input logic [31:0] epc, input logic ept,
                      input logic [31:0] etgt, input logic rv, input logic rbr,
                      input logic rtk, input logic [31:0] rtgt);
    ment_t h;
    ment_t n;
    logic  m;
    bit    can_enq;
    enq_valid       = ev;
    enq_pc          = epc;
    enq_pred_taken  = ept;
    enq_pred_target = etgt;
    res_valid       = rv;
    res_is_branch   = rbr;
    res_taken       = rtk;
    res_target      = rtgt;
    can_enq    = (mq.size() != 8);
    m          = 1'b0;
    exp_upd_en = 1'b0;
    exp_misp   = 1'b0;
    if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      if (rbr) m = (h.pt != rtk) || (h.pt && rtk && (h.tgt != rtgt));
      else     m = h.pt;
      exp_upd_en  = 1'b1;
      exp_upd_pc  = h.pc;
      exp_upd_tgt = rtgt;
      exp_upd_br  = rbr;
      exp_upd_tk  = rtk;
      exp_misp    = m;
      exp_redir   = (rbr && rtk) ? rtgt : (h.pc + 32'd4);
      if (rbr && exp_stat_br != 32'hFFFF_FFFF) exp_stat_br = exp_stat_br + 1;
      if (m && exp_stat_mp != 32'hFFFF_FFFF)   exp_stat_mp = exp_stat_mp + 1;
      if (m) mq.delete();
    end else if (rv) begin
      exp_err = 1'b1;
    end
    if (ev && can_enq && !m) begin
      n.pc  = epc;
      n.pt  = ept;
      n.tgt = etgt;
      mq.push_back(n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input logic busy);
    reset           = 1'b0;
    enq_valid       = busy;
    enq_pc          = 32'h5555_0000;
    enq_pred_taken  = busy;
    enq_pred_target = 32'h77;
    res_valid       = busy;
    res_is_branch   = busy;
    res_taken       = busy;
    res_target      = 32'h88;
    @(posedge clock);
    #1;
    reset       = 1'b1;
    enq_valid   = 1'b0;
    res_valid   = 1'b0;
    mq.delete();
    exp_upd_en  = 0; exp_upd_pc = 0; exp_upd_tgt = 0; exp_upd_br = 0; exp_upd_tk = 0;
    exp_misp    = 0; exp_redir  = 0; exp_err     = 0;
    exp_stat_br = 0; exp_stat_mp = 0;
  endtask

  task automatic check_cleared(input string tag);
    logic [31:0] got;
    got = {upd_enable, upd_is_branch, upd_taken, mispredict, res_err, empty, enq_ready};
    n_cmp++;
    if (got !== 32'h3) begin
      n_fail++;
      $display("FAIL %s_flags got=%h exp=%h", tag, got, 32'h3);
    end
    n_cmp++;
    if ({upd_pc, upd_target, redirect_pc} !== 96'h0) begin
      n_fail++;
      $display("FAIL %s_data got=%h/%h/%h exp=0", tag, upd_pc, upd_target, redirect_pc);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    check_cleared("reset");
  endtask

  task automatic test_basic();
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 32'h999);
    n_cmp++;
    if ({upd_enable, upd_taken, mispredict, empty} !== 4'b1001) begin
      n_fail++;
      $display("FAIL basic_flags got=%b exp=1001", {upd_enable, upd_taken, mispredict, empty});
    end
    n_cmp++;
    if (upd_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL basic_upd_pc got=%h exp=00000100", upd_pc);
    end
    idle();
    n_cmp++;
    if (upd_enable !== 1'b0 || upd_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL basic_hold got=%b/%h exp=0/00000100", upd_enable, upd_pc);
    end
  endtask

  task automatic test_target_mispredict();
    step(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 32'h340);
    n_cmp++;
    if ({mispredict, empty, upd_enable} !== 3'b111 || redirect_pc !== 32'h340) begin
      n_fail++;
      $display("FAIL tgt_misp got=%b%b%b/%h exp=111/00000340", mispredict, empty, upd_enable, redirect_pc);
    end
    idle();
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_fail++;
      $display("FAIL tgt_pulse got=%b exp=0", mispredict);
    end
  endtask

  task automatic test_flush();
    step(1, 32'h10, 0, 0, 0, 0, 0, 0);
    step(1, 32'h14, 0, 0, 0, 0, 0, 0);
    step(1, 32'h18, 0, 0, 0, 0, 0, 0);
    step(1, 32'h1C, 0, 0, 1, 1, 1, 32'h80);
    n_cmp++;
    if ({mispredict, empty, enq_ready} !== 3'b111 || redirect_pc !== 32'h80 || upd_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL flush got=%b%b%b/%h/%h exp=111/00000080/00000010",
               mispredict, empty, enq_ready, redirect_pc, upd_pc);
    end
    idle();
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_discard got=%b exp=1", empty);
    end
  endtask

  task automatic test_full_and_wrap();
    for (int i = 0; i < 8; i++) step(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({enq_ready, empty} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_ready got=%b exp=00", {enq_ready, empty});
    end
    step(1, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0);
    step(1, 32'hBEEF_0000, 0, 0, 1, 0, 0, 0);
    n_cmp++;
    if (enq_ready !== 1'b1 || upd_pc !== 32'h1000 || mispredict !== 1'b0) begin
      n_fail++;
      $display("FAIL full_enq_res got=%b/%h/%b exp=1/00001000/0", enq_ready, upd_pc, mispredict);
    end
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, 0);
      n_cmp++;
      if (upd_pc !== 32'h1000 + 32'(4 * i) || upd_enable !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_order i=%0d got=%h exp=%h", i, upd_pc, 32'h1000 + 32'(4 * i));
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty got=%b exp=1", empty);
    end
    for (int i = 0; i <= 20; i++) begin
      step(i < 20, 32'h2000 + 32'(4 * i), 0, 0, i > 0, 1, 0, 0);
      if (i > 0) begin
        n_cmp++;
        if (upd_pc !== 32'h2000 + 32'(4 * (i - 1)) || upd_pc !== exp_upd_pc || mispredict !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_order i=%0d got=%h exp=%h", i, upd_pc, 32'h2000 + 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_nonbranch_wrap_and_err();
    step(1, 32'hFFFF_FFFC, 1, 32'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h5678);
    n_cmp++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0 || upd_is_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL nonbr_wrap got=%b/%h exp=1/00000000", mispredict, redirect_pc);
    end
    step(0, 0, 0, 0, 1, 1, 1, 32'h4444);
    n_cmp++;
    if (res_err !== 1'b1 || upd_enable !== 1'b0 || upd_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL res_err got=%b/%b/%h exp=1/0/fffffffc", res_err, upd_enable, upd_pc);
    end
    idle();
    n_cmp++;
    if (res_err !== 1'b1) begin
      n_fail++;
      $display("FAIL res_err_sticky got=%b exp=1", res_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 32'h3000 + 32'(4 * i), 1, 32'h9000, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 32'h1); // leaves a recent mispredict/update in flight
    for (int i = 0; i < 4; i++) step(1, 32'h3100 + 32'(4 * i), 0, 0, 0, 0, 0, 0);
    do_reset(1'b1);
    check_cleared("reset_mid");
  endtask

`ifdef BRQ_STATS_EN
  task automatic test_stats();
    do_reset(1'b0);
    n_cmp++;
    if (stat_branches !== 32'h0 || stat_mispredicts !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_reset got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
    end
    step(1, 32'h100, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 32'h200, 1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 32'h340);
    n_cmp++;
    if (stat_branches !== 32'd2 || stat_mispredicts !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_count got=%0d/%0d exp=2/1", stat_branches, stat_mispredicts);
    end
  endtask
`endif

  task automatic test_random();
    logic        ev, ept, rv, rbr, rtk;
    logic [31:0] epc, etgt, rtgt;
    ment_t       h;
    for (int c = 0; c < 400; c++) begin
      ev   = ($urandom_range(0, 99) < 60);
      epc  = $urandom & 32'hFFFF_FFFC;
      ept  = 1'($urandom_range(0, 1));
      etgt = $urandom & 32'hFFFF_FFFC;
      rv   = ($urandom_range(0, 99) < 45);
      rbr  = 1'($urandom_range(0, 1));
      rtk  = 1'($urandom_range(0, 1));
      rtgt = $urandom & 32'hFFFF_FFFC;
      if (mq.size() > 0 && $urandom_range(0, 99) < 70) begin
        h = mq[0];
        if (h.pt) begin
          rbr = 1'b1; rtk = 1'b1; rtgt = h.tgt;
        end else begin
          rtk = 1'b0;
        end
      end
      step(ev, epc, ept, etgt, rv, rbr, rtk, rtgt);
      n_cmp++;
      if ({upd_enable, mispredict, res_err, upd_is_branch, upd_taken} !==
          {exp_upd_en, exp_misp, exp_err, exp_upd_br, exp_upd_tk}) begin
        n_fail++;
        $display("FAIL rnd_flags c=%0d got=%b exp=%b", c,
                 {upd_enable, mispredict, res_err, upd_is_branch, upd_taken},
                 {exp_upd_en, exp_misp, exp_err, exp_upd_br, exp_upd_tk});
      end
      n_cmp++;
      if ({empty, enq_ready} !== {mq.size() == 0, mq.size() != 8}) begin
        n_fail++;
        $display("FAIL rnd_occupancy c=%0d got=%b%b exp_size=%0d", c, empty, enq_ready, mq.size());
      end
      n_cmp++;
      if (upd_pc !== exp_upd_pc || upd_target !== exp_upd_tgt) begin
        n_fail++;
        $display("FAIL rnd_upd_data c=%0d got=%h/%h exp=%h/%h", c, upd_pc, upd_target, exp_upd_pc, exp_upd_tgt);
      end
      if (exp_misp) begin
        n_cmp++;
        if (redirect_pc !== exp_redir) begin
          n_fail++;
          $display("FAIL rnd_redirect c=%0d got=%h exp=%h", c, redirect_pc, exp_redir);
        end
      end
`ifdef BRQ_STATS_EN
      n_cmp++;
      if (stat_branches !== exp_stat_br || stat_mispredicts !== exp_stat_mp) begin
        n_fail++;
        $display("FAIL rnd_stats c=%0d got=%0d/%0d exp=%0d/%0d", c,
                 stat_branches, stat_mispredicts, exp_stat_br, exp_stat_mp);
      end
`endif
    end
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    reset           = 1'b0;
    enq_valid       = 1'b0;
    enq_pc          = '0;
    enq_pred_taken  = 1'b0;
    enq_pred_target = '0;
    res_valid       = 1'b0;
    res_is_branch   = 1'b0;
    res_taken       = 1'b0;
    res_target      = '0;
    test_reset();
    test_basic();
    test_target_mispredict();
    test_flush();
    test_full_and_wrap();
    test_nonbranch_wrap_and_err();
    test_reset_mid();
`ifdef BRQ_STATS_EN
    test_stats();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
